// File: rtl/demo_pixel_gen.sv
// Pixel source for VGAcore: scrolling checker/gradient background with a bouncing box.
// Animation state only advances at end of frame (inside vertical blank), so frames never tear.
module demo_pixel_gen #(
    parameter int          H_TOTAL_LAST = 799,
    parameter int          V_TOTAL_LAST = 523,
    parameter int          X_MIN        = 17,
    parameter int          X_MAX        = 655,
    parameter int          Y_MIN        = 11,
    parameter int          Y_MAX        = 489,
    parameter int          BOX_SIZE     = 32,
    parameter int          SPEED        = 2,
    parameter logic [11:0] BOX_COLOR    = 12'hFFF
) (
    input  logic        clk_25_175,
    input  logic        reset,
    input  logic [9:0]  hpos,
    input  logic [9:0]  vpos,
    input  logic        pause,
    output logic [11:0] pixstream,
    output logic        frame_tick,
    output logic [7:0]  frame_count
);

    localparam logic [10:0] LIM_X  = 11'(X_MAX - BOX_SIZE + 1);
    localparam logic [10:0] LIM_Y  = 11'(Y_MAX - BOX_SIZE + 1);
    localparam logic [10:0] XMIN_W = 11'(X_MIN);
    localparam logic [10:0] YMIN_W = 11'(Y_MIN);
    localparam logic [10:0] SPD_W  = 11'(SPEED);
    localparam logic [10:0] BOX_W  = 11'(BOX_SIZE);

    // One axis of the bounce: returns {dir, pos}, dir 1 = increasing.
    function automatic logic [10:0] step_axis(
        input logic [9:0]  pos,
        input logic        dir,
        input logic [10:0] lo,
        input logic [10:0] lim
    );
        logic [10:0] p;
        logic [10:0] res;
        p = {1'b0, pos};
        if (dir) begin
            if ((p + SPD_W) >= lim) begin
                res = {1'b0, lim[9:0]};
            end else begin
                res = {1'b1, 10'(p + SPD_W)};
            end
        end else begin
            if (p <= (lo + SPD_W)) begin
                res = {1'b1, lo[9:0]};
            end else begin
                res = {1'b0, 10'(p - SPD_W)};
            end
        end
        return res;
    endfunction

    logic [11:0] pix_q, pix_d;
    logic        tick_q, tick_d;
    logic [7:0]  fc_q, fc_d;
    logic [9:0]  box_x_q, box_x_d;
    logic [9:0]  box_y_q, box_y_d;
    logic        dir_x_q, dir_x_d;
    logic        dir_y_q, dir_y_d;

    logic        eof_s;
    logic        inbox_s;
    logic        carry_s;
    logic [3:0]  sx_hi_s;
    logic        c_s;

    // Next-state for animation, frame tick and the pixel word.
    always_comb begin
        eof_s   = (hpos == 10'(H_TOTAL_LAST)) && (vpos == 10'(V_TOTAL_LAST));
        tick_d  = eof_s;
        fc_d    = fc_q;
        box_x_d = box_x_q;
        box_y_d = box_y_q;
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        if (eof_s && !pause) begin
            fc_d               = fc_q + 8'd1;
            {dir_x_d, box_x_d} = step_axis(box_x_q, dir_x_q, XMIN_W, LIM_X);
            {dir_y_d, box_y_d} = step_axis(box_y_q, dir_y_q, YMIN_W, LIM_Y);
        end else begin
            fc_d = fc_q;
        end

        inbox_s = ({1'b0, hpos} >= {1'b0, box_x_q}) && ({1'b0, hpos} < ({1'b0, box_x_q} + BOX_W))
               && ({1'b0, vpos} >= {1'b0, box_y_q}) && ({1'b0, vpos} < ({1'b0, box_y_q} + BOX_W));

        // Only sx[8:5] of (hpos + frame_count) is needed, so build it from the low-half carry.
        carry_s = (6'({1'b0, hpos[4:0]}) + 6'({1'b0, fc_q[4:0]})) > 6'd31;
        sx_hi_s = hpos[8:5] + {1'b0, fc_q[7:5]} + {3'b000, carry_s};
        c_s     = sx_hi_s[0] ^ vpos[5];

        if (inbox_s) begin
            pix_d = BOX_COLOR;
        end else begin
            pix_d = {(c_s ? 4'h8 : 4'h2), vpos[8:5], sx_hi_s};
        end
    end

    // State and output registers.
    always_ff @(posedge clk_25_175 or negedge reset) begin
        if (!reset) begin
            pix_q   <= 12'h000;
            tick_q  <= 1'b0;
            fc_q    <= 8'd0;
            box_x_q <= 10'(X_MIN);
            box_y_q <= 10'(Y_MIN);
            dir_x_q <= 1'b1;
            dir_y_q <= 1'b1;
        end else begin
            pix_q   <= pix_d;
            tick_q  <= tick_d;
            fc_q    <= fc_d;
            box_x_q <= box_x_d;
            box_y_q <= box_y_d;
            dir_x_q <= dir_x_d;
            dir_y_q <= dir_y_d;
        end
    end

    assign pixstream   = pix_q;
    assign frame_tick  = tick_q;
    assign frame_count = fc_q;

endmodule

// File: tb/tb_demo_pixel_gen.sv
// Directed bench for demo_pixel_gen: reset, pixel latency, box hits, bounces, pause, wrap, async reset.
module tb_demo_pixel_gen;

    logic        clk;
    logic        reset;
    logic [9:0]  hpos;
    logic [9:0]  vpos;
    logic        pause;
    logic [11:0] pixstream;
    logic        frame_tick;
    logic [7:0]  frame_count;

    int checks   = 0;
    int failures = 0;

    // Reference animation state
    int bx, by, dx, dy, mfc;

    demo_pixel_gen dut (
        .clk_25_175 (clk),
        .reset      (reset),
        .hpos       (hpos),
        .vpos       (vpos),
        .pause      (pause),
        .pixstream  (pixstream),
        .frame_tick (frame_tick),
        .frame_count(frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] bg(input int h, input int v, input int fc);
        int sx;
        int c;
        logic [11:0] r;
        sx = (h + fc) % 1024;
        c  = ((sx >> 5) & 1) ^ ((v >> 5) & 1);
        r[11:8] = (c != 0) ? 4'h8 : 4'h2;
        r[7:4]  = 4'((v >> 5) & 15);
        r[3:0]  = 4'((sx >> 5) & 15);
        return r;
    endfunction

    task automatic axis(inout int p, inout int d, input int lo, input int lim);
        if (d == 1) begin
            if (p + 2 >= lim) begin p = lim; d = 0; end
            else p = p + 2;
        end else begin
            if (p <= lo + 2) begin p = lo; d = 1; end
            else p = p - 2;
        end
    endtask

    task automatic model_reset();
        bx = 17; by = 11; dx = 1; dy = 1; mfc = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input int h, input int v, input logic [11:0] exp, input string tag);
        hpos = 10'(h);
        vpos = 10'(v);
        step();
        chk(tag, pixstream, exp);
    endtask

    task automatic do_eof();
        hpos = 10'd799;
        vpos = 10'd523;
        step();
        chk("tick_high", {11'b0, frame_tick}, 12'h001);
        if (!pause) begin
            mfc = (mfc + 1) & 255;
            axis(bx, dx, 17, 624);
            axis(by, dy, 11, 458);
        end
        chk("frame_count", {4'h0, frame_count}, 12'(mfc));
        hpos = 10'd0;
        vpos = 10'd0;
        step();
        chk("tick_low", {11'b0, frame_tick}, 12'h000);
    endtask

    initial begin
        reset = 1'b0;
        pause = 1'b0;
        hpos  = 10'd0;
        vpos  = 10'd0;
        model_reset();

        // Reset held with counters running through an end-of-frame
        for (int i = 0; i < 20; i++) begin
            hpos = 10'(780 + i);
            vpos = 10'd523;
            step();
            chk("rst_pix", pixstream, 12'h000);
            chk("rst_tick", {11'b0, frame_tick}, 12'h000);
            chk("rst_fc", {4'h0, frame_count}, 12'h000);
        end

        // Release and one-cycle pixel latency
        reset = 1'b1;
        probe(100, 40, 12'h213, "latency_bg");
        probe(17, 11, 12'hFFF, "box_top_left");
        probe(48, 42, 12'hFFF, "box_bot_right");
        probe(49, 11, 12'h801, "box_right_edge");
        probe(17, 43, bg(17, 43, 0), "box_bottom_edge");

        // Out-of-range counters never signal end of frame
        hpos = 10'd799; vpos = 10'd1023; step();
        chk("oor_v_tick", {11'b0, frame_tick}, 12'h000);
        hpos = 10'd1023; vpos = 10'd523; step();
        chk("oor_h_tick", {11'b0, frame_tick}, 12'h000);
        hpos = 10'd0; vpos = 10'd0; step();
        chk("oor_fc", {4'h0, frame_count}, 12'h000);

        // First frame
        do_eof();
        chk("fc_one", {4'h0, frame_count}, 12'h001);
        probe(19, 13, 12'hFFF, "f1_box");
        probe(18, 13, 12'h200, "f1_left");
        probe(51, 13, 12'h801, "f1_right");

        // Pause across three frames
        pause = 1'b1;
        for (int i = 0; i < 3; i++) do_eof();
        chk("pause_fc", {4'h0, frame_count}, 12'h001);
        probe(19, 13, 12'hFFF, "pause_box");
        probe(21, 15, bg(21, 15, 1) == 12'hFFF ? 12'h000 : 12'hFFF, "pause_not_moved");
        pause = 1'b0;
        do_eof();
        chk("resume_fc", {4'h0, frame_count}, 12'h002);
        probe(21, 15, 12'hFFF, "resume_box");
        probe(20, 15, bg(20, 15, 2), "resume_left");

        // Run toward the right wall
        begin
            int n = 0;
            while (!(bx == 623 && dx == 1) && n < 400) begin do_eof(); n++; end
            checks++;
            assert (bx == 623 && dx == 1) else begin
                failures++;
                $error("FAIL reach_623 observed=%0d expected=%0d", bx, 623);
            end
        end
        probe(623, by, 12'hFFF, "x623_box");
        probe(622, by, bg(622, by, mfc), "x623_left");
        do_eof();
        probe(624, by, 12'hFFF, "x624_box");
        probe(655, by, 12'hFFF, "x624_far");
        probe(623, by, bg(623, by, mfc), "x624_left");
        do_eof();
        probe(622, by, 12'hFFF, "x622_box");
        probe(654, by, bg(654, by, mfc), "x622_right");

        // Run back toward the left wall
        begin
            int n = 0;
            while (!(bx == 18 && dx == 0) && n < 400) begin do_eof(); n++; end
            checks++;
            assert (bx == 18 && dx == 0) else begin
                failures++;
                $error("FAIL reach_18 observed=%0d expected=%0d", bx, 18);
            end
        end
        probe(18, by, 12'hFFF, "x18_box");
        do_eof();
        probe(17, by, 12'hFFF, "x17_box");
        probe(49, by, bg(49, by, mfc), "x17_right");
        do_eof();
        probe(19, by, 12'hFFF, "x19_box");
        probe(18, by, bg(18, by, mfc), "x19_left");

        // frame_count wrap
        begin
            int n = 0;
            while (mfc != 255 && n < 300) begin do_eof(); n++; end
        end
        do_eof();
        chk("fc_wrap", {4'h0, frame_count}, 12'h000);

        // Async reset right after an end-of-frame edge, before any further clock
        hpos = 10'd799; vpos = 10'd523;
        step();
        chk("pre_rst_tick", {11'b0, frame_tick}, 12'h001);
        reset = 1'b0;
        #1;
        chk("async_pix", pixstream, 12'h000);
        chk("async_tick", {11'b0, frame_tick}, 12'h000);
        chk("async_fc", {4'h0, frame_count}, 12'h000);
        step();
        reset = 1'b1;
        model_reset();
        probe(17, 11, 12'hFFF, "post_rst_box");
        probe(16, 11, bg(16, 11, 0), "post_rst_left");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
